// File: rtl/conv_pkg.sv
// Shared types and fixed-point helpers for the convolution and dense-layer MAC datapaths.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Widest accumulator any caller may hand to sat_relu.
  localparam int ACC_MAX = 64;

  function automatic int acc_width(input int dw, input int ch, input int k);
    return 2 * dw + $clog2(ch * k) + 1;
  endfunction

  function automatic logic signed [ACC_MAX-1:0] sat_hi(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [ACC_MAX-1:0] sat_lo(input int ow);
    return ~sat_hi(ow);
  endfunction

  // Saturate to a signed ow-bit range, then optionally clamp negatives to zero.
  function automatic logic signed [ACC_MAX-1:0] sat_relu(input logic signed [ACC_MAX-1:0] acc,
                                                         input logic relu, input int ow);
    logic signed [ACC_MAX-1:0] r;
    if (acc > sat_hi(ow))      r = sat_hi(ow);
    else if (acc < sat_lo(ow)) r = sat_lo(ow);
    else                       r = acc;
    if (relu && r[ACC_MAX-1]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv1d_mac_if.sv
// Window/kernel/bias request and result handshake between the window buffer, conv1d_mac and the dense stage.
interface conv1d_mac_if #(
  parameter int CH  = 8,
  parameter int LEN = 5,
  parameter int K   = 3,
  parameter int DW  = 16,
  parameter int OW  = 24
);
  localparam int OUT_N = LEN - K + 1;

  logic                          i_valid;
  logic                          o_ready;
  logic [CH*LEN-1:0][DW-1:0]     i_data;
  logic [CH*K-1:0][DW-1:0]       i_kernel;
  logic [DW-1:0]                 i_bias;
  logic                          i_relu;
  logic [OUT_N-1:0][OW-1:0]      o_weights;
  logic                          o_valid;
  logic                          i_ready;
  logic                          o_busy;

  modport master (
    output i_valid, i_data, i_kernel, i_bias, i_relu, i_ready,
    input  o_ready, o_weights, o_valid, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_kernel, i_bias, i_relu, i_ready,
    output o_ready, o_weights, o_valid, o_busy
  );
endinterface

// File: rtl/mac_unit.sv
// Pipelined multiply-accumulate: registered (a*b)>>>FRAC product, then added into a wide accumulator.
module mac_unit #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 38
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 last_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  input  logic                 load_i,
  input  logic signed [AW-1:0] bias_i,
  output logic signed [AW-1:0] sum_o,
  output logic                 done_o
);
  logic signed [2*DW-1:0] prod_full, prod_sh, prod_q;
  logic signed [AW-1:0]   addend, acc_q;
  logic                   vld_q, last_q;

  always_comb begin
    prod_full = (2*DW)'(a_i) * (2*DW)'(b_i);
    prod_sh   = prod_full >>> FRAC;
    if (vld_q) addend = AW'(prod_q);
    else       addend = '0;
  end

  assign sum_o  = acc_q + addend;
  assign done_o = last_q;

  // NOTE: sequential state uses <= so every register samples its pre-edge inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      vld_q  <= en_i;
      last_q <= en_i & last_i;
      if (en_i) prod_q <= prod_sh;
      // A finished output hands its sum to the caller this cycle, so restart from bias.
      if (load_i || last_q) acc_q <= bias_i;
      else                  acc_q <= sum_o;
    end
  end
endmodule

// File: rtl/conv1d_mac.sv
// Sequential 1-D valid-mode convolution over CH channels with one shared MAC, bias, saturation and ReLU.
module conv1d_mac
  import conv_pkg::*;
#(
  parameter int CH   = 8,
  parameter int LEN  = 5,
  parameter int K    = 3,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int OW   = 24
) (
  input logic          i_clk,
  input logic          i_rst,
  conv1d_mac_if.slave  bus
);
  localparam int OUT_N = LEN - K + 1;
  localparam int AW    = acc_width(DW, CH, K);
  localparam int JW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int DIW   = (CH * LEN > 1) ? $clog2(CH * LEN) : 1;
  localparam int KIW   = (CH * K > 1) ? $clog2(CH * K) : 1;

  state_e                    state_q, state_d;
  logic [CH*LEN-1:0][DW-1:0] data_q;
  logic [CH*K-1:0][DW-1:0]   kernel_q;
  logic [DW-1:0]             bias_q;
  logic                      relu_q;
  logic [JW-1:0]             j_q, j_d, jp_q;
  logic [CW-1:0]             c_q, c_d;
  logic [KW-1:0]             k_q, k_d;
  logic                      drain_q, drain_d;
  logic [OUT_N-1:0][OW-1:0]  weights_q;

  logic                      accept, issue, last_tap, mac_done;
  logic [DIW-1:0]            d_idx;
  logic [KIW-1:0]            k_idx;
  logic signed [AW-1:0]      bias_ext, mac_sum;
  logic [OW-1:0]             wr_val;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    c_d     = c_q;
    k_d     = k_q;
    drain_d = drain_q;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.i_valid) begin
        accept  = 1'b1;
        state_d = RUN;
        j_d     = '0;
        c_d     = '0;
        k_d     = '0;
        drain_d = 1'b0;
      end
      RUN: begin
        // drain_q: every MAC is issued, waiting for the last product to land.
        issue = !drain_q;
        if (issue) begin
          if (k_q == KW'(K - 1)) begin
            k_d = '0;
            if (c_q == CW'(CH - 1)) begin
              c_d = '0;
              if (j_q == JW'(OUT_N - 1)) drain_d = 1'b1;
              else                       j_d     = j_q + JW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        if (mac_done && jp_q == JW'(OUT_N - 1)) state_d = DONE;
      end
      DONE: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_idx    = DIW'(int'(c_q) * LEN + int'(j_q) + int'(k_q));
    k_idx    = KIW'(int'(c_q) * K + int'(k_q));
    last_tap = (k_q == KW'(K - 1)) && (c_q == CW'(CH - 1));
    bias_ext = accept ? AW'($signed(bus.i_bias)) : AW'($signed(bias_q));
    wr_val   = OW'(sat_relu(ACC_MAX'(mac_sum), relu_q, OW));
  end

  mac_unit #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_mac (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .en_i   (issue),
    .last_i (last_tap),
    .a_i    (data_q[d_idx]),
    .b_i    (kernel_q[k_idx]),
    .load_i (accept),
    .bias_i (bias_ext),
    .sum_o  (mac_sum),
    .done_o (mac_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      kernel_q  <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      j_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      jp_q      <= '0;
      drain_q   <= 1'b0;
      // NOTE: the result array is port-visible, so it is reset like any control flop.
      weights_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      c_q     <= c_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      if (accept) begin
        data_q   <= bus.i_data;
        kernel_q <= bus.i_kernel;
        bias_q   <= bus.i_bias;
        relu_q   <= bus.i_relu;
      end
      // jp_q follows the product through the MAC pipeline stage to address the write.
      if (issue)    jp_q <= j_q;
      if (mac_done) weights_q[jp_q] <= wr_val;
    end
  end

  assign bus.o_ready   = (state_q == IDLE);
  assign bus.o_busy    = (state_q == RUN);
  assign bus.o_valid   = (state_q == DONE);
  assign bus.o_weights = weights_q;
endmodule
